mole_game_sequencer: RTL and testbench

//  Round sequencer for the whack-a-mole game: schedules which mole lights, for how long,

---
 rtl/mole_game_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mole_game_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_sequencer.sv
// mole_game_sequencer - whack-a-mole round sequencer: LFSR mole pick, hit/miss judging, scoring.
// Optional MOLE_SPEEDUP_EN shortens the lit window after every hit.
module mole_game_sequencer #(
  parameter int N_MOLES   = 4,
  parameter int ON_TICKS  = 50,
  parameter int GAP_TICKS = 10,
  parameter int ROUNDS    = 16,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               busy,
  output logic               game_over
);

  localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam int RW    = $clog2(ROUNDS + 1);
  localparam int IW    = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  localparam logic [SCORE_W-1:0] SAT = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [RW-1:0]      round, round_n;
  logic [7:0]         lfsr;
  logic [N_MOLES-1:0] btn_q, press, mole_led_n;
  logic [SCORE_W-1:0] score_n, misses_n;
  logic               busy_n, game_over_n;
  logic [IW-1:0]      prev_idx, prev_idx_n, raw_idx, pick_idx;
  logic               prev_valid, prev_valid_n;
  logic [31:0]        raw_full;
  logic               do_hit, do_miss, round_end;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [TW-1:0] ON_MIN = TW'(ON_TICKS / 4);
  logic [TW-1:0] on_len, on_len_n, on_shrunk;
  assign on_shrunk = on_len - (on_len >> 3);
`else
  logic [TW-1:0] on_len;
  assign on_len = TW'(ON_TICKS);
`endif

  assign press = btn & ~btn_q;

  // Consecutive rounds never repeat a mole: a repeat pick is bumped to the next one.
  always_comb begin
    raw_full = {30'b0, lfsr[1:0]} % N_MOLES;
    raw_idx  = raw_full[IW-1:0];
    pick_idx = raw_idx;
    if (prev_valid && raw_idx == prev_idx)
      pick_idx = (raw_full == N_MOLES - 1) ? '0 : raw_idx + IW'(1);
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    round_n      = round;
    mole_led_n   = mole_led;
    score_n      = score;
    misses_n     = misses;
    busy_n       = busy;
    game_over_n  = game_over;
    prev_idx_n   = prev_idx;
    prev_valid_n = prev_valid;
`ifdef MOLE_SPEEDUP_EN
    on_len_n     = on_len;
`endif
    do_hit       = 1'b0;
    do_miss      = 1'b0;
    round_end    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          score_n      = '0;
          misses_n     = '0;
          round_n      = '0;
          game_over_n  = 1'b0;
          busy_n       = 1'b1;
          prev_valid_n = 1'b0;
          timer_n      = TW'(GAP_TICKS);
          state_n      = GAP;
`ifdef MOLE_SPEEDUP_EN
          on_len_n     = TW'(ON_TICKS);
`endif
        end
      end
      GAP: begin
        if (tick) begin
          if (timer == TW'(1)) begin
            mole_led_n   = N_MOLES'(1) << pick_idx;
            prev_idx_n   = pick_idx;
            prev_valid_n = 1'b1;
            timer_n      = on_len;
            state_n      = SHOW;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
      end
      SHOW: begin
        // A press on any dark mole is a miss even if the lit one was pressed too.
        if (|(press & ~mole_led))                  do_miss = 1'b1;
        else if (|(press & mole_led))              do_hit  = 1'b1;
        else if (tick && timer == TW'(1))          do_miss = 1'b1;
        else if (tick)                             timer_n = timer - TW'(1);
        round_end = do_hit | do_miss;
        if (do_hit && score != SAT)   score_n  = score + SCORE_W'(1);
        if (do_miss && misses != SAT) misses_n = misses + SCORE_W'(1);
`ifdef MOLE_SPEEDUP_EN
        if (do_hit) on_len_n = (on_shrunk < ON_MIN) ? ON_MIN : on_shrunk;
`endif
        if (round_end) begin
          mole_led_n = '0;
          round_n    = round + RW'(1);
          if (round_n == RW'(ROUNDS)) begin
            busy_n      = 1'b0;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else begin
            timer_n = TW'(GAP_TICKS);
            state_n = GAP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      round      <= '0;
      lfsr       <= 8'hA5;
      btn_q      <= '0;
      mole_led   <= '0;
      score      <= '0;
      misses     <= '0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      prev_idx   <= '0;
      prev_valid <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
      on_len     <= TW'(ON_TICKS);
`endif
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      round      <= round_n;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      btn_q      <= btn;
      mole_led   <= mole_led_n;
      score      <= score_n;
      misses     <= misses_n;
      busy       <= busy_n;
      game_over  <= game_over_n;
      prev_idx   <= prev_idx_n;
      prev_valid <= prev_valid_n;
`ifdef MOLE_SPEEDUP_EN
      on_len     <= on_len_n;
`endif
    end
  end

endmodule

// File: tb/tb_mole_game_sequencer.sv
// tb/tb_mole_game_sequencer.sv - scoreboard bench for mole_game_sequencer.
module tb_mole_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start2 = 1'b0, tick = 1'b1;
  logic [3:0] btn = '0, btn2 = '0, led, led2;
  logic [7:0] score, misses, score2, misses2;
  logic       busy, game_over, busy2, go2;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] s; logic [7:0] m; } exp_t;
  exp_t exp_q[$];
  logic [3:0] prev_led;

  always #5 clk = ~clk;

  mole_game_sequencer #(.N_MOLES(4), .ON_TICKS(8), .GAP_TICKS(2), .ROUNDS(4), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .btn(btn),
    .mole_led(led), .score(score), .misses(misses), .busy(busy), .game_over(game_over));

  mole_game_sequencer #(.N_MOLES(4), .ON_TICKS(50), .GAP_TICKS(2), .ROUNDS(6), .SCORE_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tick(tick), .btn(btn2),
    .mole_led(led2), .score(score2), .misses(misses2), .busy(busy2), .game_over(go2));

  task automatic push_exp(input logic [7:0] s, input logic [7:0] m);
    exp_t e;
    e.s = s; e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name, input logic [7:0] s, input logic [7:0] m,
                           input logic [3:0] l);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (s !== e.s || m !== e.m || l !== 4'b0) begin
        failures++;
        $display("FAIL %s: score=%0d misses=%0d led=%b, required score=%0d misses=%0d led=0000",
                 name, s, m, l, e.s, e.m);
      end
    end
  endtask

  task automatic wait_lit(input string name, output int dark);
    dark = 0;
    while (led == 4'b0 && dark < 100) begin
      @(negedge clk);
      if (led == 4'b0) dark++;
    end
    checks++;
    if (led == 4'b0) begin
      failures++;
      $display("FAIL %s: no mole lit after %0d cycles, required a lit mole", name, dark);
    end
  endtask

  task automatic gap_check(input string name);
    int dark;
    wait_lit(name, dark);
    checks++;
    if (dark + 1 != 2 || !$onehot(led) || led === prev_led) begin
      failures++;
      $display("FAIL %s: dark=%0d led=%b prev=%b, required dark=2 one-hot led differing from prev",
               name, dark + 1, led, prev_led);
    end
    prev_led = led;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 4'b0 || score !== 8'd0 || misses !== 8'd0 || busy !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset: led=%b score=%0d misses=%0d busy=%b go=%b, required all zero",
               led, score, misses, busy, game_over);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || led !== 4'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL start_busy: busy=%b led=%b, required busy=1 led=0000", busy, led);
    end
    @(negedge clk);
    checks++;
    if (led !== 4'b0) begin
      failures++;
      $display("FAIL start_gap2: led=%b, required 0000", led);
    end
    @(negedge clk);
    checks++;
    if (!$onehot(led)) begin
      failures++;
      $display("FAIL start_lit: led=%b, required one-hot", led);
    end
    prev_led = led;
  endtask

  task automatic test_hit;
    @(negedge clk);
    btn = led;
    push_exp(8'd1, 8'd0);
    @(negedge clk);
    pop_check("hit", score, misses, led);
    btn = '0;
    gap_check("hit_gap");
  endtask

  task automatic test_timeout;
    int n = 0;
    push_exp(8'd1, 8'd1);
    while (led != 4'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL timeout_len: lit=%0d cycles, required 8", n);
    end
    pop_check("timeout", score, misses, led);
    gap_check("timeout_gap");
  endtask

  task automatic test_wrong_and_held;
    int n = 0;
    int dark;
    btn = led | {led[2:0], led[3]};
    push_exp(8'd1, 8'd2);
    @(negedge clk);
    pop_check("wrong_press", score, misses, led);
    wait_lit("held_lit", dark);
    push_exp(8'd1, 8'd3);
    while (led != 4'b0 && n < 100) begin
      n++;
      start = (n == 3);
      @(negedge clk);
      if (n == 3) begin
        checks++;
        if (busy !== 1'b1 || score !== 8'd1 || misses !== 8'd2) begin
          failures++;
          $display("FAIL start_ignored: busy=%b score=%0d misses=%0d, required 1/1/2",
                   busy, score, misses);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL held_button: lit=%0d cycles, required 8", n);
    end
    pop_check("held_timeout", score, misses, led);
  endtask

  task automatic test_done;
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done: game_over=%b busy=%b, required 1/0", game_over, busy);
    end
    btn = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart: score=%0d misses=%0d go=%b busy=%b, required 0/0/0/1",
               score, misses, game_over, busy);
    end
  endtask

  task automatic test_reset_mid;
    int dark;
    wait_lit("reset_mid_lit", dark);
    reset = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0 || score !== 8'd0 || misses !== 8'd0 || busy !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: led=%b score=%0d misses=%0d busy=%b go=%b, required all zero",
               led, score, misses, busy, game_over);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || led !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b led=%b, required 0/0000", busy, led);
    end
  endtask

  task automatic test_speedup;
    int win[6];
    bit is_hit[6] = '{0, 1, 0, 1, 1, 0};
    logic [7:0] es = 0, em = 0;
`ifdef MOLE_SPEEDUP_EN
    win = '{50, 50, 44, 44, 39, 35};
`else
    win = '{50, 50, 50, 50, 50, 50};
`endif
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int r = 0; r < 6; r++) begin
      int n = 0;
      int guard = 0;
      while (led2 == 4'b0 && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (is_hit[r]) begin
        es++;
        push_exp(es, em);
        while (led2 != 4'b0 && n < win[r]) begin
          n++;
          if (n < win[r]) @(negedge clk);
        end
        checks++;
        if (n != win[r] || led2 == 4'b0) begin
          failures++;
          $display("FAIL window_open r%0d: open=%0d led=%b, required %0d lit cycles", r, n, led2, win[r]);
        end
        btn2 = led2;
        @(negedge clk);
        pop_check("speed_hit", score2, misses2, led2);
        btn2 = '0;
      end else begin
        em++;
        push_exp(es, em);
        while (led2 != 4'b0 && n < 200) begin
          n++;
          @(negedge clk);
        end
        checks++;
        if (n != win[r]) begin
          failures++;
          $display("FAIL window_len r%0d: lit=%0d, required %0d", r, n, win[r]);
        end
        pop_check("speed_miss", score2, misses2, led2);
      end
    end
    checks++;
    if (go2 !== 1'b1 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL speed_done: go=%b busy=%b, required 1/0", go2, busy2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_start;
    test_hit;
    test_timeout;
    test_wrong_and_held;
    test_done;
    test_reset_mid;
    test_speedup;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
